// File: rtl/mvu_ram_rdstream.sv
// mvu_ram_rdstream: walks `count` RAM addresses from `base` with a fixed `stride`,
// captures the 1-cycle-latency read data into a 2-entry skid FIFO and presents
// it as a valid/ready stream with a last-word marker. Reads are issued only when
// the FIFO plus the read in flight can still absorb them, so backpressure loses
// nothing and a ready consumer sees one word per cycle.
module mvu_ram_rdstream #(
    parameter int BDADDR = 12,
    parameter int BDWORD = 2048,
    parameter int BCNT   = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BDADDR-1:0] base,
    input  logic [BDADDR-1:0] stride,
    input  logic [BCNT-1:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [BDADDR-1:0] rd_addr,
    input  logic [BDWORD-1:0] rd_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BDWORD-1:0] out_word,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    logic [BDADDR-1:0] addr;
    logic [BDADDR-1:0] stride_q;
    logic [BDADDR-1:0] rd_addr_q;
    logic [BCNT-1:0]   remaining;
    logic              inflight;
    logic              inflight_last;

    logic [1:0]        fifo_count;
    logic [BDWORD-1:0] word0;
    logic [BDWORD-1:0] word1;
    logic              last0;
    logic              last1;

    logic              pop;
    logic              push;
    logic              issue;
    logic [2:0]        credits;

    // Credits count the words that will still be held after this edge; a new
    // read is only allowed when that leaves room for it in the 2-entry FIFO.
    always_comb begin
        pop     = out_valid & out_ready;
        push    = inflight;
        credits = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        issue   = (state == RUN) && (credits < 3'd2);
    end

    assign out_valid = (fifo_count != 2'd0);
    assign out_word  = word0;
    assign out_last  = out_valid & last0;
    assign busy      = (state != IDLE);
    assign rd_en     = issue;
    assign rd_addr   = issue ? addr : rd_addr_q;

    // Sequencer: parameter capture, address walk, in-flight tracking and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            done          <= 1'b0;
            addr          <= '0;
            stride_q      <= '0;
            rd_addr_q     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == BCNT'(1));
            if (issue) begin
                rd_addr_q <= addr;
                addr      <= addr + stride_q;
                remaining <= remaining - BCNT'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state     <= RUN;
                            addr      <= base;
                            stride_q  <= stride;
                            remaining <= count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remaining == BCNT'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid FIFO: slot 0 is always the head so the stream output falls straight
    // through from a register and stays put while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= 2'd0;
            word0      <= '0;
            word1      <= '0;
            last0      <= 1'b0;
            last1      <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        word0 <= rd_word;
                        last0 <= inflight_last;
                    end else begin
                        word1 <= rd_word;
                        last1 <= inflight_last;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    word0      <= word1;
                    last0      <= last1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        word0 <= rd_word;
                        last0 <= inflight_last;
                    end else begin
                        word0 <= word1;
                        last0 <= last1;
                        word1 <= rd_word;
                        last1 <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
